i2c_slave_regfile: RTL
======================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have the parameter SLV_ADDR, default 7'h50, meaning the 7-bit bus address it responds to.
REQ-002 The block SHALL have the parameter REG_DEPTH, default 16, meaning the register file depth; it must be a power of two, 2..256.
REQ-003 The block SHALL have the parameter SYNC_STAGES, default 2, meaning the synchronizer depth for SDA and SCL; minimum 2.
REQ-004 The block SHALL have the port clk, input, 1 bit: the system clock; the block has one clock; all logic runs on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The block SHALL have the port host_we, input, 1 bit: host register write enable.
REQ-007 The block SHALL have the port host_addr, input, $clog2(REG_DEPTH) bits: the host register index.
REQ-008 The block SHALL have the port host_wdata, input, 8 bits: host write data.
REQ-009 The block SHALL have the port host_rdata, output, 8 bits: the register contents at host_addr, combinational.
REQ-010 The block SHALL have the port bus_wr_valid, output, 1 bit: a one-cycle pulse on each register written from the bus.
REQ-011 The block SHALL have the port bus_wr_addr, output, $clog2(REG_DEPTH) bits: the index of that register, valid with bus_wr_valid.
REQ-012 The block SHALL have the port bus_wr_data, output, 8 bits: the byte written, valid with bus_wr_valid.
REQ-013 The block SHALL have the port busy, output, 1 bit: high from an address match to the following STOP.
REQ-014 The block SHALL have the port SDA, inout, 1 bit: open-drain; the block drives it only to 0 or z, never to 1.
REQ-015 The block SHALL have the port SCL, input, 1 bit: the bus clock; no clock stretching.

Function
REQ-016 Edge timing: SDA and SCL SHALL be sampled through SYNC_STAGES flops; all bus decisions SHALL use the synchronized signals and their one-cycle edge pulses.
REQ-017 START SHALL be detected as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-018 STOP SHALL force IDLE from any state and release SDA in the same cycle.
REQ-019 START in any state SHALL force ADDR with the bit counter cleared, giving repeated-start support.
REQ-020 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-021 Received bits SHALL be shifted in MSB first on the SCL rising edge.
REQ-022 The slave SHALL change SDA only on the cycle after an SCL falling edge.
REQ-023 ADDR: after 8 bits, if the address matches SLV_ADDR, the slave SHALL go to ADDR_ACK, pull SDA low for the 9th clock, latch R/W and set busy.
REQ-024 ADDR: after 8 bits, if the address does not match, the slave SHALL go to IGNORE with SDA released.
REQ-025 IGNORE SHALL exit only on START or STOP.
REQ-026 Write transfer (R/W=0): the first byte SHALL load the pointer as byte mod REG_DEPTH, and the slave SHALL ACK it in PTR_ACK.
REQ-027 Write transfer: each later byte SHALL be written to mem[ptr], pulse bus_wr_valid once, and then ptr = (ptr+1) mod REG_DEPTH; each byte SHALL be ACKed.
REQ-028 Read transfer (R/W=1): mem[ptr] SHALL be loaded into the shift register at the falling edge ending ADDR_ACK.
REQ-029 Read transfer: the slave SHALL drive SDA low for 0 bits and release it for 1 bits, MSB first.
REQ-030 Read transfer: in RDATA_ACK the master ACK SHALL be sampled on the SCL rise; ACK SHALL increment ptr (with wrap) and load the next byte.
REQ-031 Read transfer: a master NACK in RDATA_ACK SHALL move the slave to IGNORE.
REQ-032 The pointer SHALL persist across transactions, so a read without a pointer write continues from the last pointer.
REQ-033 If a host write and a bus write target the same index in the same cycle, the bus write SHALL win; different indices SHALL both complete.
REQ-034 Host writes SHALL take effect at the next clk edge; a host write to mem[ptr] during RDATA SHALL not alter the byte already loaded.

Reset
REQ-035 Reset SHALL set state IDLE, ptr 0, all registers 0, synchronizers to 1 (bus idle), SDA released, and bus_wr_valid and busy 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer, and the block SHALL ignore the bus until the next START.

Structure
REQ-037 Package i2c_pkg SHALL hold the state enum, the ACK=0/NACK=1 constants and the START/STOP helper constants.
REQ-038 Sub-module i2c_sync_edge SHALL provide the SYNC_STAGES synchronizer plus rise and fall pulses, instantiated once each for SDA and SCL.

Verification
REQ-039 Writing A0,03,11,22 then STOP SHALL produce mem[3]=11h and mem[4]=22h, two bus_wr_valid pulses, and four slave ACKs.
REQ-040 Host writes mem[15]=AAh and mem[0]=55h; writing A0,0F, then a repeated START, then reading A1 for 2 bytes with ACK and NACK SHALL return AA then 55 (wrap).
REQ-041 Sending A2 SHALL produce a NACK, no writes and busy=0; a following A0 transfer SHALL still be ACKed.
REQ-042 Writing A0,1F SHALL set ptr to 1Fh mod 16 = Fh, confirmed by a following read.
REQ-043 A STOP after 4 data bits SHALL leave the register unchanged and return the slave to IDLE with SDA released.
REQ-044 Asserting reset during RDATA SHALL release SDA at once, and a read after the next START SHALL return mem[0]=00h.

Source files
------------

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C slave register file.
// Holds the FSM state encoding, ACK/NACK levels and START/STOP classification.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned BYTE_BITS = 8;

    // Bit counter values used inside the ninth (acknowledge) clock.
    localparam logic [3:0] ACK_PENDING = 4'd8;
    localparam logic [3:0] ACK_DRIVEN  = 4'd9;

    typedef enum logic [1:0] {
        BUS_EV_NONE,
        BUS_EV_START,
        BUS_EV_STOP
    } bus_ev_t;

    // START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
    function automatic bus_ev_t bus_event(input logic scl_s, input logic sda_rise,
                                          input logic sda_fall);
        bus_ev_t ev;
        ev = BUS_EV_NONE;
        if (scl_s && sda_fall) ev = BUS_EV_START;
        if (scl_s && sda_rise) ev = BUS_EV_STOP;
        return ev;
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Host-side register access and bus-write notification signals of the slave.
// The master modport is the host/system side, the slave modport is the register file.
interface i2c_slave_regfile_if #(
    parameter int unsigned AW = 4
) ();
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          bus_wr_valid;
    logic [AW-1:0] bus_wr_addr;
    logic [7:0]    bus_wr_data;
    logic          busy;

    modport master (
        output host_we, host_addr, host_wdata,
        input  host_rdata, bus_wr_valid, bus_wr_addr, bus_wr_data, busy
    );

    modport slave (
        input  host_we, host_addr, host_wdata,
        output host_rdata, bus_wr_valid, bus_wr_addr, bus_wr_data, busy
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus line with one-cycle edge pulses.
// Resets to 1 so that an idle (pulled-up) bus produces no spurious edges.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // NOTE: clocked state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;
endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a byte register file: pointer write, burst write and burst read,
// plus a host-side port for direct register access.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h50,
    parameter int unsigned REG_DEPTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW         = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          bus_wr_valid,
    output logic [AW-1:0] bus_wr_addr,
    output logic [7:0]    bus_wr_data,
    output logic          busy,
    inout  wire           SDA,
    input  logic          SCL
);
    logic sda_s, sda_rise, sda_fall;
    logic scl_s, scl_rise, scl_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk(clk), .reset(reset), .din(SDA), .sync(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk(clk), .reset(reset), .din(SCL), .sync(scl_s), .rise(scl_rise), .fall(scl_fall)
    );

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [REG_DEPTH];
    logic [7:0]    mem_d [REG_DEPTH];

    bus_ev_t       ev;
    logic [7:0]    rx_byte;
    logic          last_bit;
    logic [AW-1:0] ptr_inc;

    assign ev       = bus_event(scl_s, sda_rise, sda_fall);
    assign rx_byte  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 4'(BYTE_BITS - 1));
    assign ptr_inc  = ptr_q + 1'b1;

    // NOTE: every always_comb output starts from a default so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_d      = mem_q;

        // Host write first so a bus write to the same index overrides it.
        if (host_we) mem_d[host_addr] = host_wdata;

        case (ev)
            BUS_EV_STOP: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                sda_oe_d  = 1'b0;
                busy_d    = 1'b0;
            end
            BUS_EV_START: begin
                state_d   = ST_ADDR;
                bit_cnt_d = '0;
                sda_oe_d  = 1'b0;
            end
            default: begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_d   = rx_byte;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (last_bit) begin
                                if (state_q == ST_ADDR) begin
                                    if (rx_byte[7:1] == SLV_ADDR) begin
                                        state_d = ST_ADDR_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end else if (state_q == ST_PTR) begin
                                    ptr_d   = rx_byte[AW-1:0];
                                    state_d = ST_PTR_ACK;
                                end else begin
                                    mem_d[ptr_q] = rx_byte;
                                    wr_valid_d   = 1'b1;
                                    wr_addr_d    = ptr_q;
                                    wr_data_d    = rx_byte;
                                    ptr_d        = ptr_inc;
                                    state_d      = ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        // First SCL fall opens the ACK bit, the second one closes it.
                        if (scl_fall) begin
                            if (bit_cnt_q == ACK_PENDING) begin
                                sda_oe_d  = 1'b1;
                                bit_cnt_d = ACK_DRIVEN;
                            end else begin
                                sda_oe_d  = 1'b0;
                                bit_cnt_d = '0;
                                if (state_q == ST_ADDR_ACK && rw_q) begin
                                    shift_d  = mem_q[ptr_q];
                                    sda_oe_d = ~mem_q[ptr_q][7];
                                    state_d  = ST_RDATA;
                                end else if (state_q == ST_ADDR_ACK) begin
                                    state_d = ST_PTR;
                                end else begin
                                    state_d = ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == ACK_PENDING) begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_RDATA_ACK;
                            end else begin
                                shift_d  = {shift_q[6:0], 1'b0};
                                sda_oe_d = ~shift_q[6];
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == ACK) begin
                                ptr_d     = ptr_inc;
                                shift_d   = mem_q[ptr_inc];
                                bit_cnt_d = ACK_DRIVEN;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (scl_fall && bit_cnt_q == ACK_DRIVEN) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = ~shift_q[7];
                            state_d   = ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            // NOTE: the register file is deliberately reset; it is flops, not a RAM macro.
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mem_q      <= mem_d;
        end
    end

    // Reset gates the driver directly so SDA is released without waiting for an edge.
    assign SDA          = (sda_oe_q && !reset) ? 1'b0 : 1'bz;
    assign host_rdata   = mem_q[host_addr];
    assign bus_wr_valid = wr_valid_q;
    assign bus_wr_addr  = wr_addr_q;
    assign bus_wr_data  = wr_data_q;
    assign busy         = busy_q;
endmodule
